// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale core: pipelined address/data phases,
// programmable wait states, byte-lane writes into a word-addressed SRAM.
module vscale_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e
);
  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wen_q, bad_q;
  logic [2:0]      size_q;
  logic [1:0]      off_q;
  logic [AW-1:0]   idx_q;
  logic            accept, bad_a, done, wr_en;
  logic [3:0]      be;
  logic [3:0][7:0] mem [DEPTH_WORDS];

  assign accept = dmem_en && !dmem_wait;
  assign done   = (state_q == DONE);

  // Base is aligned to the array size, so the range test is a tag compare.
  always_comb begin
    bad_a = (dmem_addr[31:AW+2] != BASE_ADDR[31:AW+2]);
    case (dmem_size)
      3'd0:    ;
      3'd1:    bad_a = bad_a || dmem_addr[0];
      3'd2:    bad_a = bad_a || (dmem_addr[1:0] != 2'd0);
      default: bad_a = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (dmem_en) begin
          state_d = (WC == 4'd0) ? DONE : WAIT;
          cnt_d   = WC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      bad_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q  <= dmem_wen;
        bad_q  <= bad_a;
        size_q <= dmem_size;
        off_q  <= dmem_addr[1:0];
        idx_q  <= dmem_addr[AW+1:2];
      end
    end
  end

  always_comb begin
    case (size_q)
      3'd0:    be = 4'b0001 << off_q;
      3'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wr_en = done && wen_q && !bad_q;

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx_q][b] <= dmem_wdata_delayed[8*b +: 8];
  end

  assign dmem_wait     = (state_q == WAIT);
  assign dmem_badmem_e = done && bad_q;
  assign dmem_rdata    = (done && !wen_q && !bad_q) ? mem[idx_q] : 32'd0;
endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Randomized bench for vscale_dmem_responder: three instances (0, 2, 3 wait
// states) driven as a pipelined core, checked against a byte-array model.
module tb_vscale_dmem_responder;
  localparam int DEPTH = 64;
  localparam int BYTES = 4 * DEPTH;

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           en, wen, wt, bad;
  logic [2:0][2:0]      size;
  logic [2:0][31:0]     addr, wdata, rdata;

  logic [7:0] mref [3][BYTES];
  req_t       q[$];
  logic [31:0] last_rd;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vscale_dmem_responder #(
      .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk(clk), .reset(reset), .dmem_en(en[g]), .dmem_wen(wen[g]), .dmem_size(size[g]),
      .dmem_addr(addr[g]), .dmem_wdata_delayed(wdata[g]), .dmem_wait(wt[g]),
      .dmem_rdata(rdata[g]), .dmem_badmem_e(bad[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wc_of(input int d);
    return d == 0 ? 0 : (d == 1 ? 2 : 3);
  endfunction

  function automatic bit exp_bad(input logic [2:0] s, input logic [31:0] a);
    int n;
    n = (s > 3'd2) ? 1 : (1 << s);
    return (a >= 32'(BYTES)) || (s > 3'd2) || ((a % 32'(n)) != 0);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int base;
    base = int'(a) / 4 * 4;
    return {mref[d][base+3], mref[d][base+2], mref[d][base+1], mref[d][base]};
  endfunction

  function automatic void model_write(input int d, input req_t r);
    int n, base, lane0;
    n     = 1 << r.size;
    base  = int'(r.addr) / 4 * 4;
    lane0 = (int'(r.addr) % 4) / n * n;
    for (int b = lane0; b < lane0 + n; b++) mref[d][base+b] = r.wdata[8*b +: 8];
  endfunction

  function automatic req_t mk(input logic w, input logic [2:0] s, input logic [31:0] a,
                              input logic [31:0] wd);
    req_t r;
    r.wen = w; r.size = s; r.addr = a; r.wdata = wd;
    return r;
  endfunction

  // Drive the queued requests into DUT d as a pipelined core would and check each completion.
  task automatic run(input int d, input int bubble_pct);
    req_t cur, pend;
    bit   cur_v = 0, pend_v = 0, acc = 0, done = 0;
    int   waits = 0, nacc = 0, ncomp = 0, cyc = 0, nreq;
    logic [31:0] exp_rd;
    nreq = q.size();
    while ((q.size() > 0 || cur_v || pend_v) && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (done) begin pend_v = 0; ncomp++; end
      if (acc) begin pend = cur; pend_v = 1; cur_v = 0; waits = 0; nacc++; end
      if (pend_v) wdata[d] = pend.wdata;
      if (!cur_v && q.size() > 0 && $urandom_range(99) >= bubble_pct) begin
        cur = q.pop_front(); cur_v = 1;
      end
      en[d] = cur_v;
      if (cur_v) begin
        wen[d] = cur.wen; size[d] = cur.size; addr[d] = cur.addr;
      end else begin
        wen[d] = 1'($urandom); size[d] = 3'($urandom); addr[d] = $urandom;
      end
      done = 0;
      if (pend_v) begin
        if (wt[d]) waits++;
        else begin
          done = 1;
          chk("waits", 32'(waits), 32'(wc_of(d)));
          chk("badmem", 32'(bad[d]), 32'(exp_bad(pend.size, pend.addr)));
          if (!pend.wen) begin
            exp_rd = exp_bad(pend.size, pend.addr) ? 32'd0 : model_word(d, pend.addr);
            chk("rdata", rdata[d], exp_rd);
            last_rd = rdata[d];
          end else if (!exp_bad(pend.size, pend.addr)) model_write(d, pend);
        end
      end else begin
        chk("idle_wait", 32'(wt[d]), 32'd0);
        chk("idle_rdata", rdata[d], 32'd0);
        chk("idle_bad", 32'(bad[d]), 32'd0);
      end
      acc = cur_v && !wt[d];
    end
    chk("timeout", 32'(cyc >= 5000), 32'd0);
    chk("accepts", 32'(nacc), 32'(nreq));
    chk("completions", 32'(ncomp), 32'(nreq));
    en[d] = 1'b0;
    q.delete();
  endtask

  task automatic stream(input int d, input int pairs);
    req_t w, r;
    for (int i = 0; i < pairs; i++) begin
      w.wen = 1'b1;
      w.size = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
      w.addr = ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(BYTES - 1));
      if ($urandom_range(3) != 0 && w.size <= 3'd2) w.addr = w.addr & ~((32'd1 << w.size) - 32'd1);
      w.wdata = $urandom;
      r = mk(1'b0, 3'd2, ($urandom_range(1) == 0) ? (w.addr & ~32'd3)
                                                  : 32'($urandom_range(DEPTH - 1) * 4), 32'd0);
      if ($urandom_range(7) == 0) r.size = 3'($urandom_range(3));
      q.push_back(w);
      q.push_back(r);
    end
    run(d, 25);
  endtask

  initial begin
    en = '0; wen = '0; size = '0; addr = '0; wdata = '0; last_rd = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_wait", 32'(wt[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_bad", 32'(bad[d]), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < DEPTH; i++) q.push_back(mk(1'b1, 3'd2, 32'(4 * i), $urandom));
      run(d, 0);
    end

    // Write then back-to-back read, no wait states.
    q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    run(0, 0);
    chk("t1_rd", last_rd, 32'hDEAD_BEEF);

    // Lane selection for byte and half writes.
    q.push_back(mk(1'b1, 3'd2, 32'h20, 32'h1122_3344));
    q.push_back(mk(1'b1, 3'd0, 32'h23, {8'hAA, 24'($urandom)}));
    q.push_back(mk(1'b1, 3'd1, 32'h20, {16'($urandom), 16'h5566}));
    q.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
    run(0, 0);
    chk("t2_rd", last_rd, 32'hAA22_5566);

    // Bad accesses leave the array untouched.
    q.push_back(mk(1'b0, 3'd2, 32'h02, 32'h0));
    q.push_back(mk(1'b1, 3'd1, 32'h11, 32'h1234_5678));
    q.push_back(mk(1'b0, 3'd2, 32'(BYTES), 32'h0));
    q.push_back(mk(1'b1, 3'd2, 32'(BYTES) + 32'h10, 32'h0));
    q.push_back(mk(1'b0, 3'd3, 32'h10, 32'h0));
    q.push_back(mk(1'b1, 3'd3, 32'h10, 32'h0));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    run(0, 0);
    chk("t4_keep", last_rd, 32'hDEAD_BEEF);

    // Three wait states.
    q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    run(2, 0);
    chk("t3_rd", last_rd, 32'hDEAD_BEEF);

    // Reset while a write sits in its wait states.
    @(posedge clk); #1;
    en[2] = 1'b1; wen[2] = 1'b1; size[2] = 3'd2; addr[2] = 32'h10;
    @(posedge clk); #1;
    en[2] = 1'b0; wdata[2] = 32'h0;
    chk("t5_wait", 32'(wt[2]), 32'd1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("t5_rst_wait", 32'(wt[2]), 32'd0);
    chk("t5_rst_rdata", rdata[2], 32'd0);
    chk("t5_rst_bad", 32'(bad[2]), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    run(2, 0);
    chk("t5_old", last_rd, 32'hDEAD_BEEF);

    stream(0, 64);
    stream(1, 64);
    stream(2, 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vscale_dmem_responder.md
Name: vscale_dmem_responder

Overview:
Responder (slave) end of the core's data-memory port, backed by an on-chip word-addressed SRAM array.
- Accepts the core's pipelined request: address/control in one cycle, write data one cycle later.
- Inserts a programmable number of wait states.
- Returns read data or commits write data, and flags bad accesses on dmem_badmem_e.
- Sits beside the core in the single-core test harness and in small FPGA builds.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, 16..65536)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS)
WAIT_CYCLES, 0, wait states added to every data phase (0..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dmem_en  in  1  address-phase request valid
dmem_wen  in  1  address-phase write (1) / read (0)
dmem_size  in  3  0=byte, 1=half, 2=word; other values are bad accesses
dmem_addr  in  32  byte address, address phase
dmem_wdata_delayed  in  32  write data, valid in the data phase (lane-replicated by the core)
dmem_wait  out  1  1 = current data phase not complete; core holds all inputs
dmem_rdata  out  32  read word, valid when the data phase completes on a read
dmem_badmem_e  out  1  error flag, valid when the data phase completes

Behaviour:
Accept / pipelining
- An address phase is accepted on a rising edge where dmem_en=1 and dmem_wait=0.
- On acceptance, latch wen, size, addr[1:0], the word index and the error check into the data-phase registers.
- The data phase is the cycle(s) after acceptance. It completes in the first of those cycles in which dmem_wait=0.
- A new address phase may be accepted on the same edge that completes the previous data phase (back-to-back, 1 access per cycle when WAIT_CYCLES=0).

State machine (states IDLE, WAIT, DONE)
- IDLE: no data phase pending. dmem_wait=0. Accept -> WAIT if WAIT_CYCLES>0, else DONE.
- WAIT: dmem_wait=1. Counter loads WAIT_CYCLES on accept and decrements each cycle; at count 1 -> DONE.
- DONE: dmem_wait=0; the data phase completes this cycle. Accept -> WAIT/DONE as from IDLE, else -> IDLE.

Wait-state timing
- With WAIT_CYCLES=N, dmem_wait is high for exactly N cycles after acceptance, then low for one completion cycle.

Bad access (dmem_badmem_e=1 in the completion cycle)
- Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- size=1 with addr[0]=1.
- size=2 with addr[1:0]!=0.
- size>2.
- Bad writes modify nothing; bad reads return dmem_rdata=0.

Reads
- dmem_rdata = mem[index], the full word regardless of size; the core extracts and sign-extends.
- Valid only in the completion cycle. Outside it dmem_rdata=0.

Writes
- Commit at the completion edge using dmem_wdata_delayed sampled in the completion cycle.
- Byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes.
- Unselected lanes are unchanged.

Hazards
- A read accepted on the edge a write to the same word completes sees the new data.
- A read in the same data phase can never observe the write, since one phase holds one access.

Reset
- Asynchronous. Forces IDLE, counter=0, dmem_wait=0, dmem_rdata=0, dmem_badmem_e=0.
- A pending data phase is abandoned and no write occurs.
- Array contents are not reset.
- After deassertion the first accept may occur on the next edge.

dmem_en=0 idles: no state change from IDLE/DONE beyond returning to IDLE.

Test Plan:
1. WAIT_CYCLES=0: write word 32'hDEAD_BEEF to 0x10, then back-to-back read of 0x10 -> dmem_wait never asserts; the read completion cycle gives dmem_rdata=32'hDEAD_BEEF, badmem=0.
2. Byte/half lanes: preload 0x20=32'h1122_3344; SB 0xAA at 0x23; SH 0x5566 at 0x20 -> word reads 32'hAA22_5566.
3. WAIT_CYCLES=3: read accepted at edge k -> dmem_wait=1 for cycles k+1..k+3, completion at cycle k+4 with data; inputs held constant are not re-accepted.
4. Errors: word read at 0x02, half write at 0x11, read at BASE_ADDR+4*DEPTH_WORDS, size=3 -> each completes with badmem=1; rdata=0 on reads; the array is unchanged (verify 0x10 still 32'hDEAD_BEEF).
5. Reset mid-WAIT: write of 32'h0 to 0x10 accepted with WAIT_CYCLES=3; assert reset asynchronously after 1 cycle -> outputs go to 0 immediately; a later read of 0x10 returns the old value.
6. Streaming: 64 alternating write/read pairs with random addresses and sizes, at WAIT_CYCLES 0 and 2 -> all reads match a reference byte model; exactly one completion per accept.
